// File: rtl/rr_grant_scheduler_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
package rr_sched_pkg;

  localparam int MAX_N  = 8;
  localparam int MAX_IW = 3;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  // Reference search: first set bit of req starting at ptr, wrapping modulo n.
  function automatic logic [MAX_IW-1:0] next_owner(input logic [MAX_N-1:0] req,
                                                   input logic [MAX_IW-1:0] ptr,
                                                   input int n);
    logic [MAX_IW-1:0] res;
    int j;
    res = '0;
    for (int k = n - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % n;
      if (req[j]) res = MAX_IW'(j);
    end
    return res;
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_IW-1:0] idx);
    return MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between requesters (master) and the scheduler (slave).
interface rr_grant_scheduler_if #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]  req;
  logic          rel;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          timeout;

  modport master (output req, rel, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, rel, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/rr_grant_scheduler_pick.sv
// Rotate-and-priority-encode: first requester at or after ptr, wrapping.
module rr_pick
  import rr_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  rot;
  logic [N-1:0]  low;
  logic [IW-1:0] j;

  always_comb begin
    rot = '0;
    j   = '0;
    for (int i = 0; i < N; i++) begin
      j      = IW'((int'(ptr) + i) % N);
      rot[i] = req[j];
    end
    // Isolating the lowest set bit leaves at most one match for the decode.
    low   = rot & (~rot + N'(1));
    found = |rot;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      unique0 if (low[i]) idx = IW'((int'(ptr) + i) % N);
    end
    if (found)
      assert (idx == IW'(next_owner(MAX_N'(req), MAX_IW'(ptr), N)));
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin single-owner scheduler with release strobe and hold timeout.
module rr_grant_scheduler
  import rr_sched_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int IW       = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  rr_grant_scheduler_if.slave bus
);

  localparam int HW = $clog2(MAX_HOLD);

  state_e        state_q;
  logic [N-1:0]  gnt_q;
  logic [IW-1:0] gnt_id_q;
  logic [IW-1:0] ptr_q;
  logic [HW-1:0] hold_q;
  logic          timeout_q;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] ptr_d;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign ptr_d = (gnt_id_q == IW'(N - 1)) ? '0 : gnt_id_q + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q  <= GRANT;
            gnt_q    <= N'(onehot(MAX_IW'(pick_idx)));
            gnt_id_q <= pick_idx;
            hold_q   <= '0;
          end
        end
        GRANT: begin
          // Owner release beats the hold limit, so a coincident rel never pulses timeout.
          if (bus.rel || !bus.req[gnt_id_q] || hold_q == HW'(MAX_HOLD - 1)) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= ptr_d;
            hold_q    <= '0;
            timeout_q <= !(bus.rel || !bus.req[gnt_id_q]);
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst) assert ($countones(gnt_q) <= 1);
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = |gnt_q;
  assign bus.timeout = timeout_q;

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin scheduler that shares one resource between N requesters and grants it to at most one requester at a time.
- The grant vector must have zero or one bit set. More than one bit set is a design error.
- Sits between request sources and the shared resource. Holds the grant until the owner releases it or a hold timeout expires, then rotates priority.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant (>=2).
- IW, $clog2(N), width of the owner index.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset, sampled on rising clk.
- req  in  N  per-requester request level. Bit i stays high while requester i wants the resource.
- rel  in  1  release strobe from the current owner; ignored when no grant is active.
- gnt  out  N  one-hot grant, or all zeros when idle.
- gnt_id  out  IW  index of the current owner; 0 when idle.
- busy  out  1  high while a grant is active (equals |gnt).
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0, hold_cnt=0.
  - Reset applied mid-grant drops the grant at that edge with no timeout pulse.
- State IDLE:
  - If req==0: stay in IDLE; outputs remain 0.
  - Otherwise pick the first i with req[i]=1, searching ptr, ptr+1, ... and wrapping modulo N.
  - At the next edge: gnt=1<<i, gnt_id=i, busy=1, hold_cnt=0, state=GRANT.
  - Latency from request to grant is 1 cycle.
- State GRANT (owner = gnt_id). Evaluate in this priority order:
  1. rel=1 or req[owner]=0: normal release. Next edge: gnt=0, busy=0, ptr=(owner+1) mod N, state=IDLE, no timeout pulse.
  2. Else if hold_cnt==MAX_HOLD-1: forced release. Same updates as case 1, plus timeout=1 for exactly that cycle.
  3. Else: hold_cnt increments; gnt is unchanged.
- Rel and timeout in the same cycle: treated as a normal release; timeout stays 0.
- Turnaround: every release is followed by one IDLE cycle with gnt=0, so there is no back-to-back grant without a bubble.
- A grant lasts at most MAX_HOLD cycles.
- Requests from non-owners during GRANT are ignored until IDLE.
- Pointer wrap: owner N-1 releases, so ptr=0.
- rel during IDLE has no effect.
- Priority selection is a unique0 decode over the rotated request vector: zero or one match is legal.
- Invariant: $countones(gnt) <= 1 on every cycle. The RTL carries an immediate assertion for it.
- hold_cnt width is $clog2(MAX_HOLD). No overflow is possible because the counter caps at MAX_HOLD-1.

Decomposition:
- Shared package rr_sched_pkg:
  - state enum (IDLE, GRANT) as a 1-bit logic typedef.
  - Function next_owner(req, ptr) returning the index.
  - Function onehot(idx) returning the N-bit vector.
- Sub-module rr_pick: combinational rotate-and-priority-encode.
  - Inputs req and ptr; outputs found and idx.
  - Implemented with unique0 if/case so an illegal multi-match is caught by simulation.
- Top-level rr_grant_scheduler holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
- Reset then single requester: rst 2 cycles, req=4'b0100 → gnt=4'b0100, gnt_id=2 one cycle later. Drop req → gnt=0 next cycle, ptr=3.
- Round-robin fairness: req=4'b1111 held, each owner pulses rel after 2 cycles → grant order 0,1,2,3,0 with one idle bubble between grants.
- Hold timeout, MAX_HOLD=16: req=4'b0010, never release → gnt held 16 cycles, then timeout=1 for one cycle, gnt=0, next grant to 1 again after the bubble.
- Simultaneous rel and timeout on cycle 16 → gnt released, timeout stays 0.
- Wrap and skip: ptr=3 (after owner 2 releases), req=4'b0101 → next grant to 0, not 2.
- Reset mid-grant: rst during GRANT → gnt=0, ptr=0, timeout=0 at that edge. Random 10k-cycle run with random req/rel never violates the one-hot-or-zero invariant.
